// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-core memory port arbiter: FSM state
// encoding and the grant index values used for the last-grant pointer.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam logic GRANT_C0 = 1'b0;
    localparam logic GRANT_C1 = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Shared memory/cache port. The arbiter is the master (issues requests);
// the memory is the slave (returns ready and read data).
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20
);
    logic                    mem_req;
    logic                    mem_we;
    logic [ADDRESS_BITS-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic                    mem_ready;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. Holds the last-grant pointer; on a
// tie the core not served last wins, a lone requester always wins.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant selection from the current requests and pointer.
    always_comb begin
        // NOTE: default assignment first so no path leaves grant unassigned (no latch).
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == GRANT_C0) ? 2'b10 : 2'b01;
        end
    end

    // Pointer advances only when a grant is actually taken.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant <= GRANT_C1;
        end else if (update_en && (req != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between the MEM stages of two cores.
// Round-robin grant in IDLE, access held in BUSY until mem_ready, one-cycle
// done pulse in DONE. Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 20,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    c0_load,
    input  logic                    c0_store,
    input  logic [ADDRESS_BITS-1:0] c0_address,
    input  logic [DATA_WIDTH-1:0]   c0_store_data,
    input  logic                    c1_load,
    input  logic                    c1_store,
    input  logic [ADDRESS_BITS-1:0] c1_address,
    input  logic [DATA_WIDTH-1:0]   c1_store_data,
    output logic                    c0_stall,
    output logic                    c1_stall,
    output logic                    c0_done,
    output logic                    c1_done,
    output logic [DATA_WIDTH-1:0]   c0_load_data,
    output logic [DATA_WIDTH-1:0]   c1_load_data,
    mem_port_arbiter_if.master      mem,
    output logic                    timeout_err
);

    arb_state_t            state;
    logic                  grant_q;
    logic [1:0]            req;
    logic [1:0]            grant;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] fill_data;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign req      = {c1_load | c1_store, c0_load | c0_store};
    assign c0_stall = req[0] & ~c0_done;
    assign c1_stall = req[1] & ~c1_done;

    // A watchdog completion returns zero instead of memory data.
    assign fill_data = mem.mem_ready ? mem.mem_rdata : '0;

    rr_arbiter_2 u_rr (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .update_en (state == IDLE),
        .grant     (grant)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] timeout_cnt;

    assign timeout_hit = (timeout_cnt == CNT_LAST);
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Arbitration FSM with registered memory-port and completion outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant_q       <= GRANT_C0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            c0_done       <= 1'b0;
            c1_done       <= 1'b0;
            c0_load_data  <= '0;
            c1_load_data  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            timeout_cnt   <= '0;
            timeout_err   <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            c0_done <= 1'b0;
            c1_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        state       <= BUSY;
                        grant_q     <= grant[1];
                        mem.mem_req <= 1'b1;
                        if (grant[1]) begin
                            mem.mem_we    <= c1_store & ~c1_load;
                            mem.mem_addr  <= c1_address;
                            mem.mem_wdata <= c1_store_data;
                        end else begin
                            mem.mem_we    <= c0_store & ~c0_load;
                            mem.mem_addr  <= c0_address;
                            mem.mem_wdata <= c0_store_data;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        timeout_cnt <= '0;
`endif
                    end
                end
                BUSY: begin
                    if (mem.mem_ready || timeout_hit) begin
                        state       <= DONE;
                        mem.mem_req <= 1'b0;
                        if (grant_q == GRANT_C1) begin
                            c1_done <= 1'b1;
                            if (!mem.mem_we) c1_load_data <= fill_data;
                        end else begin
                            c0_done <= 1'b1;
                            if (!mem.mem_we) c0_load_data <= fill_data;
                        end
`ifdef MEM_ARB_TIMEOUT_EN
                        if (!mem.mem_ready) timeout_err <= 1'b1;
`endif
                    end else begin
`ifdef MEM_ARB_TIMEOUT_EN
                        timeout_cnt <= timeout_cnt + CNT_W'(1);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        c0_load, c0_store, c1_load, c1_store;
    logic [19:0] c0_address, c1_address;
    logic [31:0] c0_store_data, c1_store_data;
    logic        c0_stall, c1_stall, c0_done, c1_done;
    logic [31:0] c0_load_data, c1_load_data;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic exp_terr = 1'b0;

    mem_port_arbiter_if #(.DATA_WIDTH(32), .ADDRESS_BITS(20)) mem_bus ();

    mem_port_arbiter #(
        .DATA_WIDTH     (32),
        .ADDRESS_BITS   (20),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .c0_load       (c0_load),
        .c0_store      (c0_store),
        .c0_address    (c0_address),
        .c0_store_data (c0_store_data),
        .c1_load       (c1_load),
        .c1_store      (c1_store),
        .c1_address    (c1_address),
        .c1_store_data (c1_store_data),
        .c0_stall      (c0_stall),
        .c1_stall      (c1_stall),
        .c0_done       (c0_done),
        .c1_done       (c1_done),
        .c0_load_data  (c0_load_data),
        .c1_load_data  (c1_load_data),
        .mem           (mem_bus),
        .timeout_err   (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        l0, s0;
        logic [19:0] a0;
        logic [31:0] d0;
        logic        l1, s1;
        logic [19:0] a1;
        logic [31:0] d1;
        int          k;
        logic [31:0] rdata;
        int          g;
        logic        we;
        logic [19:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld0, ld1;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {c0_load, c0_store, c1_load, c1_store} = 4'b0;
        c0_address = '0; c1_address = '0;
        c0_store_data = '0; c1_store_data = '0;
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        exp_terr = 1'b0;
        #1;
        check("rst_mem_req",  mem_bus.mem_req, 0);
        check("rst_mem_we",   mem_bus.mem_we, 0);
        check("rst_mem_addr", mem_bus.mem_addr, 0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 0);
        check("rst_done",     {c1_done, c0_done}, 0);
        check("rst_ld0",      c0_load_data, 0);
        check("rst_ld1",      c1_load_data, 0);
        check("rst_terr",     timeout_err, 0);
    endtask

    // Starts in an IDLE cycle with requests already driven; ends in the DONE cycle.
    task automatic run_access(input int core, input logic we, input logic [19:0] addr,
                              input logic [31:0] wdata, input int k, input logic [31:0] rdata,
                              input logic [31:0] ld0, input logic [31:0] ld1);
        logic r0, r1;
        mem_bus.mem_ready = 1'b0;
        #1;
        r0 = c0_load | c0_store;
        r1 = c1_load | c1_store;
        check("idle_mem_req", mem_bus.mem_req, 0);
        check("idle_stall",   {c1_stall, c0_stall}, {r1, r0});
        tick();
        for (int j = 1; j <= k; j++) begin
            check("busy_mem_req", mem_bus.mem_req, 1);
            check("busy_we",      mem_bus.mem_we, we);
            check("busy_addr",    mem_bus.mem_addr, addr);
            check("busy_wdata",   mem_bus.mem_wdata, wdata);
            check("busy_done",    {c1_done, c0_done}, 0);
            check("busy_stall",   {c1_stall, c0_stall}, {r1, r0});
            if (j == k) begin
                mem_bus.mem_ready = 1'b1;
                mem_bus.mem_rdata = rdata;
            end
            tick();
            mem_bus.mem_ready = 1'b0;
            mem_bus.mem_rdata = $urandom;
        end
        check("done_mem_req", mem_bus.mem_req, 0);
        check("done_pulse",   {c1_done, c0_done}, (core == 1) ? 2'b10 : 2'b01);
        check("done_ld0",     c0_load_data, ld0);
        check("done_ld1",     c1_load_data, ld1);
        check("done_terr",    timeout_err, exp_terr);
        check("done_stall",   {c1_stall, c0_stall}, (core == 1) ? {1'b0, r0} : {r1, 1'b0});
        // Stray ready outside BUSY must be ignored.
        mem_bus.mem_ready = 1'($urandom_range(0, 1));
    endtask

    vec_t        vecs[8];
    vec_t        v;
    logic        pend[2], mld[2], mst[2];
    logic [19:0] ra[2];
    logic [31:0] rd[2];
    logic [31:0] eld[2];
    logic [31:0] model_mem[8];
    logic [31:0] rdv;
    logic        model_last, mwe;
    int          w, kind;

    task automatic drive_model_cores();
        c0_load = pend[0] & mld[0]; c0_store = pend[0] & mst[0];
        c1_load = pend[1] & mld[1]; c1_store = pend[1] & mst[1];
        c0_address = ra[0]; c0_store_data = rd[0];
        c1_address = ra[1]; c1_store_data = rd[1];
    endtask

    initial begin
        //           l0 s0 a0        d0      l1 s1 a1        d1      k  rdata          g  we addr      wdata   ld0            ld1
        vecs[0] = '{1, 0, 20'h00010, 32'h0,  0, 0, 20'h0,    32'h0,  1, 32'hDEADBEEF, 0, 0, 20'h00010, 32'h0,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 0, 20'h0,     32'h0,  1, 0, 20'h00020, 32'h0, 2, 32'h12345678, 1, 0, 20'h00020, 32'h0,  32'hDEADBEEF, 32'h12345678};
        vecs[2] = '{1, 0, 20'h00030, 32'hA0, 1, 0, 20'h00040, 32'hB0, 1, 32'hCAFEF00D, 0, 0, 20'h00030, 32'hA0, 32'hCAFEF00D, 32'h12345678};
        vecs[3] = '{0, 1, 20'h00050, 32'hAA, 0, 1, 20'h00060, 32'hBB, 3, 32'hFFFFFFFF, 1, 1, 20'h00060, 32'hBB, 32'hCAFEF00D, 32'h12345678};
        vecs[4] = '{1, 1, 20'h00070, 32'h55, 0, 0, 20'h0,    32'h0,  1, 32'h0BADC0DE, 0, 0, 20'h00070, 32'h55, 32'h0BADC0DE, 32'h12345678};
        vecs[5] = '{0, 1, 20'h00080, 32'h99, 0, 0, 20'h0,    32'h0,  2, 32'h11112222, 0, 1, 20'h00080, 32'h99, 32'h0BADC0DE, 32'h12345678};
        vecs[6] = '{1, 0, 20'hFFFFF, 32'h1,  1, 0, 20'h00001, 32'h2, 1, 32'hA5A5A5A5, 1, 0, 20'h00001, 32'h2,  32'h0BADC0DE, 32'hA5A5A5A5};
        vecs[7] = '{0, 0, 20'h0,     32'h0,  1, 1, 20'h12345, 32'h3, 4, 32'h5A5A5A5A, 1, 0, 20'h12345, 32'h3,  32'h0BADC0DE, 32'h5A5A5A5A};

        // Vector table: one access per entry, pointer history carried across entries.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            c0_load = v.l0; c0_store = v.s0; c0_address = v.a0; c0_store_data = v.d0;
            c1_load = v.l1; c1_store = v.s1; c1_address = v.a1; c1_store_data = v.d1;
            run_access(v.g, v.we, v.addr, v.wdata, v.k, v.rdata, v.ld0, v.ld1);
            {c0_load, c0_store, c1_load, c1_store} = 4'b0;
            tick();
        end

        // Simultaneous stores after reset: core 0 first, core 1 stalled throughout.
        do_reset();
        c0_store = 1'b1; c0_address = 20'h4; c0_store_data = 32'h11;
        c1_store = 1'b1; c1_address = 20'h8; c1_store_data = 32'h22;
        run_access(0, 1, 20'h4, 32'h11, 1, 32'h0, 32'h0, 32'h0);
        c0_store = 1'b0;
        tick();
        run_access(1, 1, 20'h8, 32'h22, 2, 32'h0, 32'h0, 32'h0);
        c1_store = 1'b0;
        tick();

        // Continuous loads from both cores: grants alternate 0,1,0,1...
        do_reset();
        c0_load = 1'b1; c0_address = 20'h100;
        c1_load = 1'b1; c1_address = 20'h200;
        eld[0] = '0; eld[1] = '0;
        for (int i = 0; i < 8; i++) begin
            w = i % 2;
            eld[w] = 32'h1000 + 32'(i);
            run_access(w, 0, (w == 1) ? 20'h200 : 20'h100, 32'h0, 1 + (i % 3),
                       32'h1000 + 32'(i), eld[0], eld[1]);
            tick();
        end

        // Reset while BUSY with ready withheld: access abandoned, no done pulse.
        do_reset();
        c0_load = 1'b1; c0_address = 20'h777;
        tick();
        for (int j = 0; j < 3; j++) begin
            check("rst_busy_mem_req", mem_bus.mem_req, 1);
            check("rst_busy_done", c0_done, 0);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_abandon_mem_req", mem_bus.mem_req, 0);
        check("rst_abandon_done", {c1_done, c0_done}, 0);
        run_access(0, 0, 20'h777, 32'h0, 1, 32'h600D600D, 32'h600D600D, 32'h0);
        c0_load = 1'b0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // Watchdog: a load that never gets ready completes after 4 BUSY cycles with data 0.
        do_reset();
        c0_load = 1'b1; c0_address = 20'h33;
        run_access(0, 0, 20'h33, 32'h0, 1, 32'h77777777, 32'h77777777, 32'h0);
        tick();
        mem_bus.mem_ready = 1'b0;
        tick();
        for (int j = 0; j < 4; j++) begin
            check("to_busy_mem_req", mem_bus.mem_req, 1);
            check("to_busy_done", c0_done, 0);
            tick();
        end
        check("to_done", {c1_done, c0_done}, 2'b01);
        check("to_load_data", c0_load_data, 0);
        check("to_err_set", timeout_err, 1);
        exp_terr = 1'b1;
        c0_load = 1'b0;
        tick();
        tick();
        check("to_err_sticky", timeout_err, 1);
        c1_load = 1'b1; c1_address = 20'h44;
        run_access(1, 0, 20'h44, 32'h0, 2, 32'h44444444, 32'h0, 32'h44444444);
        c1_load = 1'b0;
        tick();
`endif

        // Randomized traffic against a transaction-level model with a small memory.
        do_reset();
        model_last = 1'b1;
        eld[0] = '0; eld[1] = '0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = $urandom;
        for (int n = 0; n < 80; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (!pend[c] && ($urandom_range(0, 2) != 0)) begin
                    kind    = $urandom_range(0, 2);
                    pend[c] = 1'b1;
                    mld[c]  = (kind != 1);
                    mst[c]  = (kind != 0);
                    ra[c]   = 20'($urandom_range(0, 7));
                    rd[c]   = $urandom;
                end
            end
            drive_model_cores();
            if (!pend[0] && !pend[1]) begin
                mem_bus.mem_ready = 1'b0;
                #1;
                check("gap_mem_req", mem_bus.mem_req, 0);
                check("gap_stall", {c1_stall, c0_stall}, 0);
                tick();
                continue;
            end
            if (pend[0] && pend[1]) w = model_last ? 0 : 1;
            else                    w = pend[0] ? 0 : 1;
            model_last = (w == 1);
            mwe = mst[w] & ~mld[w];
            rdv = model_mem[ra[w][2:0]];
            if (mwe) model_mem[ra[w][2:0]] = rd[w];
            else     eld[w] = rdv;
            run_access(w, mwe, ra[w], rd[w], $urandom_range(1, 4), rdv, eld[0], eld[1]);
            pend[w] = 1'b0;
            drive_model_cores();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
